// File: rtl/pc_gen.sv
// pc_gen: MIPS fetch-stage program counter with redirect priority exception > branch > held branch > +4.
// Latency: redirects land on pc_o one edge later; fetch_req_o held high while stalled or not ready.
// Optional PC_BRANCH_HOLD_EN keeps a branch seen while blocked and applies it on the next advance.
module pc_gen #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
    parameter int          STALL_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               exception,
    input  logic [31:0]        exception_pc_i,
    input  logic               branch_enable_i,
    input  logic [31:0]        branch_addr_i,
    input  logic               fetch_ready_i,
    output logic               fetch_req_o,
    output logic [31:0]        pc_o,
    output logic [31:0]        exception_type_o,
    output logic               pend_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        req_q;
    logic        adv;

    assign adv = req_q & fetch_ready_i & ~(|stall);

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q  <= RESET_PC;
            req_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            req_q <= 1'b1;
        end
    end

`ifdef PC_BRANCH_HOLD_EN
    typedef enum logic {RUN, PEND} state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pend_q;
    logic [31:0] pend_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            pend_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        pend_d  = pend_q;
        if (exception) begin
            pc_d    = exception_pc_i;
            state_d = RUN;
            pend_d  = 32'h0;
        end else if (adv && branch_enable_i) begin
            pc_d    = branch_addr_i;
            state_d = RUN;
        end else if (adv && (state_q == PEND)) begin
            pc_d    = pend_q;
            state_d = RUN;
        end else if (adv) begin
            pc_d = pc_q + 32'd4;
        end else if (branch_enable_i) begin
            // Newest blocked branch wins over any earlier held target.
            pend_d  = branch_addr_i;
            state_d = PEND;
        end
    end

    assign pend_o = (state_q == PEND);
`else
    // Legacy behaviour: a branch arriving while blocked is dropped.
    always_comb begin
        pc_d = pc_q;
        if (exception) begin
            pc_d = exception_pc_i;
        end else if (adv && branch_enable_i) begin
            pc_d = branch_addr_i;
        end else if (adv) begin
            pc_d = pc_q + 32'd4;
        end
    end

    assign pend_o = 1'b0;
`endif

    assign pc_o             = pc_q;
    assign fetch_req_o      = req_q;
    assign exception_type_o = {(pc_q[1:0] != 2'b00), 31'h0};

endmodule

// File: tb/tb_pc_gen.sv
// Table-driven bench for pc_gen; expectations adapt to PC_BRANCH_HOLD_EN.
module tb_pc_gen;

`ifdef PC_BRANCH_HOLD_EN
    localparam bit H = 1'b1;
`else
    localparam bit H = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  stall;
    logic        exception;
    logic [31:0] exception_pc_i;
    logic        branch_enable_i;
    logic [31:0] branch_addr_i;
    logic        fetch_ready_i;
    logic        fetch_req_o;
    logic [31:0] pc_o;
    logic [31:0] exception_type_o;
    logic        pend_o;

    always #5 clk = ~clk;

    pc_gen #(.RESET_PC(32'hbfc0_0000), .STALL_W(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .exception        (exception),
        .exception_pc_i   (exception_pc_i),
        .branch_enable_i  (branch_enable_i),
        .branch_addr_i    (branch_addr_i),
        .fetch_ready_i    (fetch_ready_i),
        .fetch_req_o      (fetch_req_o),
        .pc_o             (pc_o),
        .exception_type_o (exception_type_o),
        .pend_o           (pend_o)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  stall;
        logic        exc;
        logic [31:0] epc;
        logic        br;
        logic [31:0] baddr;
        logic        rdy;
        logic [31:0] x_pc;
        logic        x_req;
        logic        x_pend;
        logic [31:0] x_et;
    } vec_t;

    vec_t tv[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(logic r, logic [3:0] s, logic e, logic [31:0] epc,
                                logic b, logic [31:0] ba, logic rd,
                                logic [31:0] xpc, logic xreq, logic xpend, logic [31:0] xet);
        vec_t v;
        v.rst = r; v.stall = s; v.exc = e; v.epc = epc; v.br = b; v.baddr = ba; v.rdy = rd;
        v.x_pc = xpc; v.x_req = xreq; v.x_pend = xpend; v.x_et = xet;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    // Addresses that depend on whether blocked branches are held
    localparam logic [31:0] A10 = H ? 32'hbfc0_0100 : 32'hbfc0_0014;
    localparam logic [31:0] A11 = A10 + 32'd4;
    localparam logic [31:0] A25 = H ? 32'h0000_0700 : 32'h0000_0508;
    localparam logic [31:0] A28 = H ? 32'h0000_0b00 : A25 + 32'd4;

    initial begin
        localparam logic [3:0] S = 4'b0010;
        rst = 1'b0; stall = '0; exception = 1'b0; exception_pc_i = '0;
        branch_enable_i = 1'b0; branch_addr_i = '0; fetch_ready_i = 1'b1;

        //          rst stall exc epc            br baddr          rdy  pc            req pend et
        tv.push_back(mk(0, 0, 0, 0,             0, 0,             1, 32'hbfc0_0000, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0,             0, 0,             1, 32'hbfc0_0000, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 0,             0, 0,             1, 32'hbfc0_0000, 1, 0, 0));
        tv.push_back(mk(1, 0, 0, 0,             0, 0,             1, 32'hbfc0_0004, 1, 0, 0));
        tv.push_back(mk(1, 0, 0, 0,             0, 0,             1, 32'hbfc0_0008, 1, 0, 0));
        tv.push_back(mk(1, 0, 0, 0,             0, 0,             1, 32'hbfc0_000c, 1, 0, 0));
        tv.push_back(mk(1, 0, 0, 0,             0, 0,             1, 32'hbfc0_0010, 1, 0, 0));
        // branch during a 3-cycle stall
        tv.push_back(mk(1, S, 0, 0,             1, 32'hbfc0_0100, 1, 32'hbfc0_0010, 1, H, 0));
        tv.push_back(mk(1, S, 0, 0,             0, 0,             1, 32'hbfc0_0010, 1, H, 0));
        tv.push_back(mk(1, S, 0, 0,             0, 0,             1, 32'hbfc0_0010, 1, H, 0));
        tv.push_back(mk(1, 0, 0, 0,             0, 0,             1, A10,           1, 0, 0));
        tv.push_back(mk(1, 0, 0, 0,             0, 0,             1, A11,           1, 0, 0));
        // exception preempts held branch
        tv.push_back(mk(1, S, 0, 0,             1, 32'h0000_0200, 1, A11,           1, H, 0));
        tv.push_back(mk(1, S, 1, 32'hbfc0_0380, 0, 0,             1, 32'hbfc0_0380, 1, 0, 0));
        tv.push_back(mk(1, S, 0, 0,             0, 0,             1, 32'hbfc0_0380, 1, 0, 0));
        tv.push_back(mk(1, 0, 0, 0,             0, 0,             1, 32'hbfc0_0384, 1, 0, 0));
        // fetch_ready backpressure
        for (int i = 0; i < 4; i++)
            tv.push_back(mk(1, 0, 0, 0,         0, 0,             0, 32'hbfc0_0384, 1, 0, 0));
        tv.push_back(mk(1, 0, 0, 0,             0, 0,             1, 32'hbfc0_0388, 1, 0, 0));
        tv.push_back(mk(1, 0, 0, 0,             0, 0,             1, 32'hbfc0_038c, 1, 0, 0));
        // exception and branch together: exception wins
        tv.push_back(mk(1, 0, 1, 32'h0000_0500, 1, 32'h0000_0600, 1, 32'h0000_0500, 1, 0, 0));
        tv.push_back(mk(1, 0, 0, 0,             0, 0,             1, 32'h0000_0504, 1, 0, 0));
        // not-ready behaves as stall for branch holding
        tv.push_back(mk(1, 0, 0, 0,             1, 32'h0000_0700, 0, 32'h0000_0504, 1, H, 0));
        tv.push_back(mk(1, 0, 0, 0,             0, 0,             1, A25,           1, 0, 0));
        // newer blocked branch overwrites held one
        tv.push_back(mk(1, S, 0, 0,             1, 32'h0000_0a00, 1, A25,           1, H, 0));
        tv.push_back(mk(1, S, 0, 0,             1, 32'h0000_0b00, 1, A25,           1, H, 0));
        tv.push_back(mk(1, 0, 0, 0,             0, 0,             1, A28,           1, 0, 0));
        // live branch on advance overrides held target
        tv.push_back(mk(1, S, 0, 0,             1, 32'h0000_0c00, 1, A28,           1, H, 0));
        tv.push_back(mk(1, 0, 0, 0,             1, 32'h0000_0d00, 1, 32'h0000_0d00, 1, 0, 0));
        tv.push_back(mk(1, 0, 0, 0,             0, 0,             1, 32'h0000_0d04, 1, 0, 0));
        // address error and wrap
        tv.push_back(mk(1, 0, 1, 32'hbfc0_0002, 0, 0,             1, 32'hbfc0_0002, 1, 0, 32'h8000_0000));
        tv.push_back(mk(1, 0, 0, 0,             0, 0,             1, 32'hbfc0_0006, 1, 0, 32'h8000_0000));
        tv.push_back(mk(1, 0, 1, 32'hffff_fffc, 0, 0,             1, 32'hffff_fffc, 1, 0, 0));
        tv.push_back(mk(1, 0, 0, 0,             0, 0,             1, 32'h0000_0000, 1, 0, 0));
        tv.push_back(mk(1, 0, 0, 0,             0, 0,             1, 32'h0000_0004, 1, 0, 0));
        // reset mid-operation beats exception and clears held branch
        tv.push_back(mk(1, S, 0, 0,             1, 32'h0000_0900, 1, 32'h0000_0004, 1, H, 0));
        tv.push_back(mk(0, S, 1, 32'h0000_1234, 1, 32'h0000_0900, 1, 32'hbfc0_0000, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 0,             0, 0,             1, 32'hbfc0_0000, 1, 0, 0));
        tv.push_back(mk(1, 0, 0, 0,             0, 0,             1, 32'hbfc0_0004, 1, 0, 0));

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            rst             = tv[i].rst;
            stall           = tv[i].stall;
            exception       = tv[i].exc;
            exception_pc_i  = tv[i].epc;
            branch_enable_i = tv[i].br;
            branch_addr_i   = tv[i].baddr;
            fetch_ready_i   = tv[i].rdy;
            @(posedge clk);
            #1;
            check("pc",    i, pc_o,                 tv[i].x_pc);
            check("req",   i, {31'h0, fetch_req_o}, {31'h0, tv[i].x_req});
            check("pend",  i, {31'h0, pend_o},      {31'h0, tv[i].x_pend});
            check("etype", i, exception_type_o,     tv[i].x_et);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
